// File: rtl/lat_monitor.sv
// lat_monitor: receive-side latency checker for delayed one-cycle pulse sources.
// A rising edge on start opens a measurement; the matching done pulse closes
// it and reports the latency in cycles, compared against the expectation
// captured at the edge. A missing done raises a one-cycle timeout after
// MAX_WAIT cycles. A done pulse outside a measurement sets the sticky stray flag.
// Optional build macro LAT_MON_STATS_EN: when defined, max_lat tracks the
// largest reported latency since reset. When undefined, max_lat is 0.
// The expectation port is named expect_lat because "expect" is a reserved
// word in SystemVerilog.
module lat_monitor #(
  parameter int CW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          done,
  input  logic [CW-1:0] expect_lat,
  output logic          busy,
  output logic          lat_valid,
  output logic [CW-1:0] lat_count,
  output logic          mismatch,
  output logic          timeout,
  output logic          stray,
  output logic [CW-1:0] max_lat
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_REPORT = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_CW  = CW'(MAX_WAIT);

  state_t        state_r;
  state_t        state_next_s;
  logic          start_q_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] exp_q_r;
  logic          edge_s;
  logic          launch_s;
  logic          hit_s;
  logic          expire_s;

  assign edge_s = start & ~start_q_r;

  // Decode the events of the current cycle (done wins over timeout in WAIT).
  always_comb begin
    launch_s = 1'b0;
    hit_s    = 1'b0;
    expire_s = 1'b0;
    if (state_r == ST_IDLE) begin
      launch_s = edge_s;
    end else if (state_r == ST_WAIT) begin
      hit_s    = done;
      expire_s = ~done & (cnt_r == MAX_CW);
    end else begin
      launch_s = 1'b0;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (hit_s) begin
          state_next_s = ST_REPORT;
        end else if (expire_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_REPORT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Edge history, latency counter and captured expectation.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q_r <= 1'b0;
      cnt_r     <= '0;
      exp_q_r   <= '0;
    end else begin
      start_q_r <= start;
      if (launch_s) begin
        exp_q_r <= expect_lat;
        cnt_r   <= CNT_ONE;
      end else if ((state_r == ST_WAIT) && !hit_s && !expire_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Registered status outputs; pulses are aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      lat_valid <= 1'b0;
      lat_count <= '0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
      stray     <= 1'b0;
    end else begin
      busy      <= (state_next_s != ST_IDLE);
      lat_valid <= hit_s;
      timeout   <= expire_s;
      if (hit_s) begin
        lat_count <= cnt_r;
        mismatch  <= (cnt_r != exp_q_r);
      end
      if (done && (state_r != ST_WAIT)) begin
        stray <= 1'b1;
      end
    end
  end

`ifdef LAT_MON_STATS_EN
  // Running maximum of reported latencies, updated alongside lat_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_lat <= '0;
    end else if (hit_s && (cnt_r > max_lat)) begin
      max_lat <= cnt_r;
    end
  end
`else
  assign max_lat = '0;
`endif

endmodule

// File: tb/tb_lat_monitor.sv
// tb_lat_monitor: scoreboard bench for lat_monitor (CW=8, MAX_WAIT=15).
// Expected reports and timeouts are queued when a measurement is launched and
// popped by a monitor whenever the DUT pulses lat_valid or timeout.
module tb_lat_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] expect_lat;
  logic       busy;
  logic       lat_valid;
  logic [7:0] lat_count;
  logic       mismatch;
  logic       timeout;
  logic       stray;
  logic [7:0] max_lat;

  typedef struct {
    bit is_to;
    int lat;
    bit mm;
    int mx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   run_max = 0;
  int   last_lat = 0;
  bit   last_mm = 1'b0;
  bit   stray_exp = 1'b0;

  lat_monitor #(.CW(8), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .expect_lat(expect_lat), .busy(busy), .lat_valid(lat_valid),
    .lat_count(lat_count), .mismatch(mismatch), .timeout(timeout),
    .stray(stray), .max_lat(max_lat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (lat_valid || timeout) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, lat_valid, timeout}, 0);
      end else begin
        e = sb.pop_front();
        check("kind_timeout", timeout, e.is_to);
        check("kind_valid", lat_valid, !e.is_to);
        if (!e.is_to) begin
          check("lat_count", lat_count, e.lat);
          check("mismatch", mismatch, e.mm);
          check("max_lat", max_lat, e.mx);
        end
      end
    end
  end

  // One measurement: edge in cycle 0, done in cycle d (d>=1).
  task automatic meas(input int e, input int d, input bit hold, input bit done0);
    exp_t x;
    logic [7:0] ev;
    ev = e[7:0];
    check("idle_busy", busy, 0);
    start = 1'b1; expect_lat = ev; done = done0;
    if (done0) stray_exp = 1'b1;
    if (d > run_max) run_max = d;
    x.is_to = 1'b0; x.lat = d; x.mm = (d != e);
`ifdef LAT_MON_STATS_EN
    x.mx = run_max;
`else
    x.mx = 0;
`endif
    sb.push_back(x);
    last_lat = d; last_mm = x.mm;
    tick();
    for (int c = 1; c <= d + 1; c++) begin
      check("busy", busy, 1);
      check("lat_valid_cycle", lat_valid, (c == d + 1) ? 1 : 0);
      start = hold; done = (c == d); expect_lat = ev ^ 8'hFF;
      tick();
    end
    done = 1'b0;
    check("busy_after", busy, 0);
    check("held_lat", lat_count, d);
    check("held_mm", mismatch, x.mm);
    check("stray_flag", stray, stray_exp);
    tick();
    check("no_retrigger", busy, 0);
    start = 1'b0;
    tick();
  endtask

  // Edge with no done: timeout pulse in cycle 16, start toggled during WAIT.
  task automatic tmo(input int e);
    exp_t x;
    check("to_idle_busy", busy, 0);
    start = 1'b1; expect_lat = e[7:0]; done = 1'b0;
    x.is_to = 1'b1; x.lat = 0; x.mm = 1'b0; x.mx = 0;
    sb.push_back(x);
    tick();
    for (int c = 1; c <= 15; c++) begin
      check("to_busy", busy, 1);
      check("to_early", timeout, 0);
      start = (c < 14) && (c % 2 == 0);
      tick();
    end
    check("to_pulse", timeout, 1);
    check("to_state_idle", busy, 0);
    check("to_no_valid", lat_valid, 0);
    tick();
    check("to_one_cycle", timeout, 0);
    check("to_lat_kept", lat_count, last_lat);
    check("to_mm_kept", mismatch, last_mm);
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; done = 1'b0; expect_lat = 8'd0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_lat", lat_count, 0);
    check("rst_stray", stray, 0);
    check("rst_max", max_lat, 0);
    reset = 1'b0;
    tick();

    meas(2, 2, 1'b0, 1'b0);    // delay-1 source, matching expectation
    meas(2, 4, 1'b0, 1'b0);    // delay-3 source, wrong expectation
    tmo(9);                    // mismatch and lat_count must survive a timeout
    meas(15, 15, 1'b0, 1'b0);  // done in the last legal cycle
    meas(3, 3, 1'b0, 1'b1);    // done in cycle 0 is stray, measurement continues
    meas(4, 4, 1'b1, 1'b0);    // start held through the report

    // Reset in cycle 3 of a measurement; start stays high across the release.
    start = 1'b1; expect_lat = 8'd3;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_max = 0; stray_exp = 1'b0; last_lat = 0; last_mm = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", lat_valid, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_lat", lat_count, 0);
    check("mid_rst_mm", mismatch, 0);
    check("mid_rst_stray", stray, 0);
    check("mid_rst_max", max_lat, 0);

    meas(3, 3, 1'b0, 1'b0);    // launched by the still-high start
    meas(7, 7, 1'b0, 1'b0);
    meas(2, 2, 1'b0, 1'b0);

    tick(); tick();
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
